// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding slot: captures a request, holds it until granted,
// and reports whether its held destination matches either issue read address.
module rf_wb_slot
    import rf_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_valid,
    input  wb_req_t           fill_req,
    output logic              fill_ready,
    input  logic              drain,
    output logic              full,
    output wb_req_t           entry,
    input  logic [ADDR_W-1:0] match_addr1,
    input  logic [ADDR_W-1:0] match_addr2,
    output logic              match1,
    output logic              match2
);

    logic accept;

    assign fill_ready = !full || drain;
    assign accept     = fill_valid && fill_ready;
    assign match1     = full && (entry.addr == match_addr1);
    assign match2     = full && (entry.addr == match_addr2);

    // NOTE: a refill on the same edge as a drain must win, otherwise the new entry is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (accept) begin
            full  <= 1'b1;
            entry <= fill_req;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and load writeback paths, with pending flags for the issue read ports.
module rf_wb_arbiter
    import rf_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_din,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_pending,
    output logic              rd2_pending
);

    wb_req_t req0_pkt, req1_pkt, entry0, entry1, sel;
    logic    full0, full1, grant0, grant1;
    logic    s0_hit1, s0_hit2, s1_hit1, s1_hit2;
    req_id_t last_grant;

    assign req0_pkt = '{addr: req0_addr, data: req0_data};
    assign req1_pkt = '{addr: req1_addr, data: req1_data};

    rf_wb_slot u_slot0 (
        .clk         (clk),
        .rst         (rst),
        .fill_valid  (req0_valid),
        .fill_req    (req0_pkt),
        .fill_ready  (req0_ready),
        .drain       (grant0),
        .full        (full0),
        .entry       (entry0),
        .match_addr1 (rd1_addr),
        .match_addr2 (rd2_addr),
        .match1      (s0_hit1),
        .match2      (s0_hit2)
    );

    rf_wb_slot u_slot1 (
        .clk         (clk),
        .rst         (rst),
        .fill_valid  (req1_valid),
        .fill_req    (req1_pkt),
        .fill_ready  (req1_ready),
        .drain       (grant1),
        .full        (full1),
        .entry       (entry1),
        .match_addr1 (rd1_addr),
        .match_addr2 (rd2_addr),
        .match1      (s1_hit1),
        .match2      (s1_hit2)
    );

    // On contention the slot that did not win last time goes first.
    assign grant0 = full0 && (!full1 || last_grant == REQ_LOAD);
    assign grant1 = full1 && (!full0 || last_grant == REQ_ALU);
    assign sel    = grant0 ? entry0 : entry1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= REQ_LOAD;
            rf_write_en <= 1'b0;
            rf_w_addr   <= '0;
            rf_din      <= '0;
        end else if (grant0 || grant1) begin
            last_grant  <= grant0 ? REQ_ALU : REQ_LOAD;
            rf_w_addr   <= sel.addr;
            rf_din      <= sel.data;
            rf_write_en <= (sel.addr != REG_ZERO);
        end else begin
            rf_write_en <= 1'b0;
        end
    end

    // The output stage counts as in flight: the register file shows it one cycle later.
    assign rd1_pending = (rd1_addr != REG_ZERO) &&
                         (s0_hit1 || s1_hit1 || (rf_write_en && rf_w_addr == rd1_addr));
    assign rd2_pending = (rd2_addr != REG_ZERO) &&
                         (s0_hit2 || s1_hit2 || (rf_write_en && rf_w_addr == rd2_addr));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a transaction-level model predicts readies,
// pending flags and the timed sequence of register writes.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid, req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr, rf_w_addr, rd1_addr, rd2_addr;
    logic [DATA_W-1:0] req0_data, req1_data, rf_din;
    logic              rf_write_en, rd1_pending, rd2_pending;

    logic              v [2];
    logic [ADDR_W-1:0] a [2];
    logic [DATA_W-1:0] d [2];

    assign req0_valid = v[0];
    assign req0_addr  = a[0];
    assign req0_data  = d[0];
    assign req1_valid = v[1];
    assign req1_addr  = a[1];
    assign req1_data  = d[1];

    rf_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_write_en (rf_write_en),
        .rf_w_addr   (rf_w_addr),
        .rf_din      (rf_din),
        .rd1_addr    (rd1_addr),
        .rd2_addr    (rd2_addr),
        .rd1_pending (rd1_pending),
        .rd2_pending (rd2_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t exp_q [$];

    // Transaction-level model: what each requester holds, whose turn it is,
    // and which destination is in the write stage.
    bit                m_full [2];
    wb_req_t           m_slot [2];
    int                m_last;
    bit                m_wr_en;
    logic [ADDR_W-1:0] m_wr_addr;
    bit                taken [2];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_pending(input logic [ADDR_W-1:0] ad);
        return (ad != 0) && ((m_full[0] && m_slot[0].addr == ad) ||
                             (m_full[1] && m_slot[1].addr == ad) ||
                             (m_wr_en && m_wr_addr == ad));
    endfunction

    function automatic void model_reset();
        m_full    = '{0, 0};
        m_last    = 1;
        m_wr_en   = 0;
        m_wr_addr = '0;
    endfunction

    // One clock cycle: predict and compare at negedge, advance the model at posedge.
    task automatic step();
        int g;
        bit rdy [2];
        @(negedge clk);
        if (m_full[0] && m_full[1]) g = 1 - m_last;
        else if (m_full[0])         g = 0;
        else if (m_full[1])         g = 1;
        else                        g = -1;
        for (int i = 0; i < 2; i++) rdy[i] = !m_full[i] || (g == i);
        check(req0_ready == rdy[0], "req0_ready", req0_ready, rdy[0]);
        check(req1_ready == rdy[1], "req1_ready", req1_ready, rdy[1]);
        check(rd1_pending == m_pending(rd1_addr), "rd1_pending", rd1_pending, m_pending(rd1_addr));
        check(rd2_pending == m_pending(rd2_addr), "rd2_pending", rd2_pending, m_pending(rd2_addr));
        for (int i = 0; i < 2; i++) taken[i] = v[i] && rdy[i];
        if (g >= 0 && m_slot[g].addr != 0)
            exp_q.push_back('{m_slot[g].addr, m_slot[g].data, cyc + 1});
        @(posedge clk);
        m_wr_en = (g >= 0) && (m_slot[g].addr != 0);
        if (g >= 0) begin
            m_wr_addr = m_slot[g].addr;
            m_full[g] = 0;
            m_last    = g;
        end
        for (int i = 0; i < 2; i++)
            if (taken[i]) begin
                m_full[i] = 1;
                m_slot[i] = '{addr: a[i], data: d[i]};
            end
        #1;
        for (int i = 0; i < 2; i++) if (taken[i]) v[i] = 1'b0;
    endtask

    task automatic offer(input int i, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt);
        v[i] = 1'b1;
        a[i] = ad;
        d[i] = dt;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Monitor: every write the register file sees must be the next expected one, on time.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_write_en) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_write", {rf_w_addr, rf_din}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({rf_w_addr, rf_din} == {e.addr, e.data}, "write_content",
                          {rf_w_addr, rf_din}, {e.addr, e.data});
                    check(cyc == e.cyc, "write_cycle", cyc, e.cyc);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check(1'b0, "missing_write", 0, {e.addr, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v = '{0, 0};
        a = '{0, 0};
        d = '{0, 0};
        rd1_addr = 5;
        rd2_addr = 3;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check(rf_write_en == 1'b0, "reset_write_en", rf_write_en, 0);
        check(rf_w_addr == '0, "reset_w_addr", rf_w_addr, 0);
        check(rf_din == '0, "reset_din", rf_din, 0);
        check(req0_ready && req1_ready, "reset_ready", {req0_ready, req1_ready}, 2'b11);
        check(!rd1_pending && !rd2_pending, "reset_pending", {rd1_pending, rd2_pending}, 0);
        @(posedge clk);
        #1;

        // Single write, then round-robin contention with a late third request.
        offer(0, 5, 32'hDEADBEEF);
        steps(4);
        offer(0, 3, 32'h11);
        offer(1, 4, 32'h22);
        step();
        offer(0, 7, 32'h33);
        steps(5);

        // Both requesters valid every cycle.
        for (int k = 0; k < 8; k++) begin
            if (!v[0]) offer(0, 5'($urandom_range(1, 31)), $urandom);
            if (!v[1]) offer(1, 5'($urandom_range(1, 31)), $urandom);
            step();
        end
        v = '{0, 0};
        steps(4);

        // Zero register is consumed silently.
        rd1_addr = 0;
        offer(1, 0, 32'hFFFFFFFF);
        steps(4);

        // Slot1 loses arbitration while req1 holds x9.
        rd1_addr = 9;
        offer(1, 2, 32'h44);
        step();
        offer(0, 1, 32'h66);
        offer(1, 6, 32'h77);
        step();
        offer(1, 9, 32'h55);
        steps(6);

        // Asynchronous reset with both slots full and a write in the output stage.
        offer(0, 10, 32'hA0);
        offer(1, 11, 32'hB0);
        step();
        offer(0, 12, 32'hA1);
        offer(1, 13, 32'hB1);
        step();
        #1;
        rst = 1'b1;
        #1;
        check(rf_write_en == 1'b0, "async_reset_write_en", rf_write_en, 0);
        exp_q.delete();
        model_reset();
        v = '{0, 0};
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        steps(4);

        // Randomised traffic on a small address range to force collisions.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                if (!v[i] && ($urandom_range(0, 3) != 0))
                    offer(i, 5'($urandom_range(0, 7)), $urandom);
            rd1_addr = 5'($urandom_range(0, 7));
            rd2_addr = 5'($urandom_range(0, 7));
            step();
        end
        v = '{0, 0};
        steps(5);
        check(exp_q.size() == 0, "drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: req0 is the execute/ALU path and req1 is the multi-cycle/memory-load path. Each requester has a one-entry holding slot, and a round-robin arbiter drains the slots into a registered write-port stage. The block also gives the issue logic per-read-port pending flags, so reads of not-yet-written destinations can be stalled. It sits between the writeback sources and the register file's din/w_addr/write_en inputs.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width (32 registers; register 0 is hard-wired zero)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  ALU writeback valid
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  ALU slot can accept
req1_valid  in  1  load/multi-cycle writeback valid
req1_addr  in  ADDR_W  destination register
req1_data  in  DATA_W  result
req1_ready  out  1  load slot can accept
rf_write_en  out  1  to register file write_en
rf_w_addr  out  ADDR_W  to register file w_addr
rf_din  out  DATA_W  to register file din
rd1_addr  in  ADDR_W  issue-stage read address, port 1
rd2_addr  in  ADDR_W  issue-stage read address, port 2
rd1_pending  out  1  write to rd1_addr still in flight
rd2_pending  out  1  write to rd2_addr still in flight

Behaviour:
- Reset (async, immediate):
  - Both slots empty; output stage invalid.
  - rf_write_en=0, rf_w_addr=0, rf_din=0.
  - last_grant=1, so req0 wins the first contention.
  - reqN_ready=1 once the slots are empty; pending flags=0.
- Handshake:
  - Transfer on posedge when reqN_valid & reqN_ready.
  - reqN_ready = slotN empty OR slotN granted this cycle (same-cycle drain and refill allowed).
  - Requester holds valid/addr/data stable until ready.
- Slot: captures addr/data on transfer and becomes full next cycle. Clears on grant unless refilled in the same edge.
- Arbitration (combinational, single cycle):
  - Only slot0 full -> grant0. Only slot1 full -> grant1.
  - Both full -> grant the slot != last_grant.
  - last_grant updates only when a grant occurs.
  - Starvation bound: a full slot is granted within 2 cycles.
- Output stage (registered):
  - On grant: rf_w_addr/rf_din <= slot contents; rf_write_en <= (addr != 0).
  - With no grant: rf_write_en <= 0; addr/data hold their last value.
  - Writes to register 0 are accepted and consumed, but never assert rf_write_en.
- Latency: accepted at edge N -> slot full in cycle N+1 -> rf_write_en high in cycle N+2 if uncontended (register file writes at end of N+2). Worst case N+3.
- Throughput: one register write per cycle sustained; each requester can sustain one per cycle while the other is idle.
- Pending flags (combinational):
  - rdK_pending = rdK_addr != 0 AND (slot0 full & addr match OR slot1 full & addr match OR rf_write_en & rf_w_addr match).
  - The register file reads asynchronously, so a write in cycle N+2 is visible on the read ports from cycle N+3. Pending therefore covers through N+2.
- Same destination in both slots: order follows grant order. Software/issue logic must not rely on ordering across requesters; the pending flags remain set until both writes drain.
- Reset mid-operation: held and in-flight writes are discarded, and rf_write_en drops immediately.

Decomposition:
- Package rf_wb_pkg:
  - Constants DATA_W=32, ADDR_W=5, REG_ZERO=0.
  - Typedef wb_req_t {addr, data}.
  - Enum req_id_t {REQ_ALU=0, REQ_LOAD=1}.
- Sub-module rf_wb_slot: one-entry holding register with fill/drain/full and address-match output. Instantiated twice.
- Arbiter and output stage stay in the top module.

Test Plan:
- Single write: req0 x5=0xDEADBEEF at edge 0 -> rf_write_en=1, rf_w_addr=5, rf_din=0xDEADBEEF in cycle 2 only; rd1_addr=5 gives rd1_pending=1 in cycles 1–2 and 0 in cycle 3.
- Contention after reset: req0 x3=0x11 and req1 x4=0x22 in the same cycle -> x3 written in cycle 2, x4 in cycle 3; req0 sent x7=0x33 in cycle 1 -> written in cycle 4 (round robin).
- Sustained streams:
  - Both requesters are valid every cycle for 8 cycles.
  - Required: rf_write_en is high every cycle from cycle 2 on, grants alternate, and each readyN is low at most 1 cycle in 2.
  - Required: no transaction is lost or duplicated (scoreboard against the register file model).
- Zero register: req1 x0=0xFFFFFFFF -> req1_ready stays high, rf_write_en never asserts, rd1_pending=0 with rd1_addr=0.
- Backpressure hold: slot1 full and losing arbitration, req1_valid held with x9=0x55 -> req1_ready=0 until slot1 is granted, then accepted the same cycle; x9=0x55 is eventually written exactly once.
- Async reset: assert rst mid-cycle with both slots full -> rf_write_en=0 immediately, both readys=1 after release, and no stale write appears.
